// File: rtl/watch_pkg.sv
// Shared time-field widths, limits and alarm FSM state encoding.
package watch_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RINGING = 2'd1;
  localparam state_t ST_SNOOZED = 2'd2;
endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: one-cycle pulse when the level goes 0 -> 1 between samples.
module btn_edge (
  input  logic clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_btn;
  end

  assign o_pulse = i_btn & ~r_prev;
endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm clock controller: per-slot time edit/arm plus ring/snooze FSM.
module multi_alarm_ctrl import watch_pkg::*; #(
  parameter  int N_ALARM    = 4,
  parameter  int BEEP_SEC   = 30,
  parameter  int SNOOZE_MIN = 5,
  parameter  int MAX_SNOOZE = 3,
  localparam int SEL_W      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               resetTime,
  input  logic               sec_tick,
  input  logic               min_tick,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic [MIN_W-1:0]   cur_min,
  input  logic [SEL_W-1:0]   sel,
  input  logic               setValue,
  input  logic               upTime,
  input  logic               nextDigit,
  input  logic               armToggle,
  input  logic               stop,
  input  logic               snooze,
  output logic [HOUR_W-1:0]  disp_hour,
  output logic [MIN_W-1:0]   disp_min,
  output logic               edit_field,
  output logic [N_ALARM-1:0] armed,
  output logic               alarmBeep,
  output logic [SEL_W-1:0]   ring_idx
);
  localparam int BEEP_W = $clog2(BEEP_SEC + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_MIN + 1);
  localparam int CNT_W  = $clog2(MAX_SNOOZE + 1);

  logic [3:0] w_btn, w_edge;
  logic       w_up, w_nd, w_arm, w_snz;

  // Bit order: upTime, nextDigit, armToggle, snooze.
  assign w_btn = {snooze, armToggle, nextDigit, upTime};
  btn_edge u_btn [3:0] (.clk(clk), .i_rst(resetTime), .i_btn(w_btn), .o_pulse(w_edge));
  assign {w_snz, w_arm, w_nd, w_up} = w_edge;

  logic [N_ALARM-1:0][HOUR_W-1:0] r_hour;
  logic [N_ALARM-1:0][MIN_W-1:0]  r_min;
  logic [N_ALARM-1:0]             r_armed;
  logic                           r_field, r_set_prev;
  logic                           w_sel_ok, w_set_rise, w_field;

  assign w_sel_ok   = 32'(sel) < N_ALARM;
  assign w_set_rise = setValue & ~r_set_prev;
  // An increment in the same cycle edit mode opens lands on the hour field.
  assign w_field    = w_set_rise ? 1'b0 : r_field;

  always_ff @(posedge clk) begin
    if (resetTime) begin
      r_hour     <= '0;
      r_min      <= '0;
      r_armed    <= '0;
      r_field    <= 1'b0;
      r_set_prev <= 1'b0;
    end else begin
      r_set_prev <= setValue;
      if (w_arm && w_sel_ok) r_armed[sel] <= ~r_armed[sel];
      if (w_set_rise)                r_field <= 1'b0;
      else if (setValue && w_nd)     r_field <= ~r_field;
      if (setValue && w_up && w_sel_ok) begin
        if (!w_field) r_hour[sel] <= (r_hour[sel] == HOUR_MAX) ? '0 : r_hour[sel] + 1'b1;
        else          r_min[sel]  <= (r_min[sel] == MIN_MAX)   ? '0 : r_min[sel] + 1'b1;
      end
    end
  end

  logic             w_hit;
  logic [SEL_W-1:0] w_hit_idx;

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (r_armed[i] && r_hour[i] == cur_hour && r_min[i] == cur_min) begin
        w_hit     = 1'b1;
        w_hit_idx = SEL_W'(i);
      end
    end
  end

  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [BEEP_W-1:0] r_beep;
  logic [SNZ_W-1:0] r_snz_min;
  logic [CNT_W-1:0] r_snz_cnt;
  logic             w_disarm, w_end;

  assign w_disarm = w_arm && w_sel_ok && (sel == r_idx) && r_armed[r_idx];
  assign w_end    = w_disarm || stop;

  always_ff @(posedge clk) begin
    if (resetTime) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_beep    <= '0;
      r_snz_min <= '0;
      r_snz_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (min_tick && w_hit) begin
          r_state   <= ST_RINGING;
          r_idx     <= w_hit_idx;
          r_beep    <= '0;
          r_snz_cnt <= '0;
        end
        ST_RINGING: begin
          if (w_end) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else if (w_snz) begin
            if (r_snz_cnt < CNT_W'(MAX_SNOOZE)) begin
              r_state   <= ST_SNOOZED;
              r_snz_cnt <= r_snz_cnt + 1'b1;
              r_snz_min <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
            end
          end else if (sec_tick) begin
            if (r_beep == BEEP_W'(BEEP_SEC - 1)) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
            end else begin
              r_beep <= r_beep + 1'b1;
            end
          end
        end
        ST_SNOOZED: begin
          if (w_end) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else if (min_tick) begin
            if (r_snz_min == SNZ_W'(SNOOZE_MIN - 1)) begin
              r_state <= ST_RINGING;
              r_beep  <= '0;
            end else begin
              r_snz_min <= r_snz_min + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign disp_hour  = w_sel_ok ? r_hour[sel] : '0;
  assign disp_min   = w_sel_ok ? r_min[sel]  : '0;
  assign edit_field = r_field;
  assign armed      = r_armed;
  assign alarmBeep  = (r_state == ST_RINGING);
  assign ring_idx   = r_idx;
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl with a per-cycle reference model.
module tb_multi_alarm_ctrl;
  localparam int N = 4, BEEP = 30, SNZ = 5, MAXS = 3;
  localparam int B_UP = 0, B_ND = 1, B_ARM = 2, B_SNZ = 3;

  logic clk = 1'b0;
  logic resetTime = 1'b1, sec_tick = 0, min_tick = 0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [1:0] sel = '0;
  logic setValue = 0, upTime = 0, nextDigit = 0, armToggle = 0, stop = 0, snooze = 0;
  logic [4:0] disp_hour;
  logic [5:0] disp_min;
  logic edit_field, alarmBeep;
  logic [N-1:0] armed;
  logic [1:0] ring_idx;

  multi_alarm_ctrl #(.N_ALARM(N), .BEEP_SEC(BEEP), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk(clk), .resetTime(resetTime), .sec_tick(sec_tick), .min_tick(min_tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .sel(sel), .setValue(setValue),
    .upTime(upTime), .nextDigit(nextDigit), .armToggle(armToggle), .stop(stop),
    .snooze(snooze), .disp_hour(disp_hour), .disp_min(disp_min), .edit_field(edit_field),
    .armed(armed), .alarmBeep(alarmBeep), .ring_idx(ring_idx));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 ringing, 2 snoozed; times kept as plain ints.
  int  mh[N], mm[N];
  bit  marm[N];
  int  mst = 0, midx = 0, beep_left = 0, snz_left = 0, snz_used = 0;
  bit  mfield = 0;
  bit  p_up, p_nd, p_arm, p_snz, p_set;

  task automatic model_step();
    bit e_up, e_nd, e_arm, e_snz, dis, go_idle;
    int hit, f, s;
    s = int'(sel);
    if (resetTime) begin
      for (int i = 0; i < N; i++) begin mh[i] = 0; mm[i] = 0; marm[i] = 0; end
      mst = 0; midx = 0; beep_left = 0; snz_left = 0; snz_used = 0; mfield = 0;
      p_up = 0; p_nd = 0; p_arm = 0; p_snz = 0; p_set = 0;
      return;
    end
    e_up = upTime && !p_up; e_nd = nextDigit && !p_nd;
    e_arm = armToggle && !p_arm; e_snz = snooze && !p_snz;
    dis = e_arm && s == midx && marm[midx];
    hit = -1;
    for (int i = N - 1; i >= 0; i--)
      if (marm[i] && mh[i] * 60 + mm[i] == int'(cur_hour) * 60 + int'(cur_min)) hit = i;
    go_idle = 0;
    if (mst == 0) begin
      if (min_tick && hit >= 0) begin mst = 1; midx = hit; beep_left = BEEP; snz_used = 0; end
    end else if (dis || stop) go_idle = 1;
    else if (mst == 1) begin
      if (e_snz) begin
        if (snz_used < MAXS) begin snz_used++; mst = 2; snz_left = SNZ; end
        else go_idle = 1;
      end else if (sec_tick) begin
        beep_left--;
        if (beep_left == 0) go_idle = 1;
      end
    end else if (min_tick) begin
      snz_left--;
      if (snz_left == 0) begin mst = 1; beep_left = BEEP; end
    end
    if (go_idle) begin mst = 0; midx = 0; end
    if (e_arm) marm[s] = !marm[s];
    f = (setValue && !p_set) ? 0 : int'(mfield);
    if (setValue && e_up) begin
      if (f == 0) mh[s] = (mh[s] + 1) % 24;
      else        mm[s] = (mm[s] + 1) % 60;
    end
    if (setValue && !p_set) mfield = 0;
    else if (setValue && e_nd) mfield = !mfield;
    p_up = upTime; p_nd = nextDigit; p_arm = armToggle; p_snz = snooze; p_set = setValue;
  endtask

  // Inputs change only just after posedge, so at negedge they equal what the next posedge samples.
  always @(negedge clk) begin
    int ea;
    if (chk_en) begin
      ea = 0;
      for (int i = 0; i < N; i++) ea |= int'(marm[i]) << i;
      chk("m_disp_hour", int'(disp_hour), mh[int'(sel)]);
      chk("m_disp_min", int'(disp_min), mm[int'(sel)]);
      chk("m_edit_field", int'(edit_field), int'(mfield));
      chk("m_armed", int'(armed), ea);
      chk("m_alarmBeep", int'(alarmBeep), int'(mst == 1));
      chk("m_ring_idx", int'(ring_idx), midx);
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input int b);
    case (b)
      B_UP:  upTime = 1;
      B_ND:  nextDigit = 1;
      B_ARM: armToggle = 1;
      default: snooze = 1;
    endcase
    tick();
    upTime = 0; nextDigit = 0; armToggle = 0; snooze = 0;
    tick();
  endtask

  task automatic presses(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic mtick();
    min_tick = 1; tick(); min_tick = 0; tick();
  endtask

  task automatic stick();
    sec_tick = 1; tick(); sec_tick = 0; tick();
  endtask

  task automatic reopen_edit();
    setValue = 0; tick(); setValue = 1; tick();
  endtask

  initial begin
    tick(); tick();
    resetTime = 0; chk_en = 1;
    chk("rst_hour", int'(disp_hour), 0);
    chk("rst_min", int'(disp_min), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_beep", int'(alarmBeep), 0);
    chk("rst_field", int'(edit_field), 0);

    // Slot 2 to 07:30.
    sel = 2; setValue = 1; tick();
    presses(B_UP, 7); press(B_ND); presses(B_UP, 30);
    chk("s2_hour", int'(disp_hour), 7);
    chk("s2_min", int'(disp_min), 30);
    chk("s2_field", int'(edit_field), 1);
    sel = 0; tick();
    chk("s0_hour", int'(disp_hour), 0);
    chk("s0_min", int'(disp_min), 0);

    // Slot 1: wrap checks with no carry between fields.
    sel = 1; reopen_edit();
    chk("field_reset", int'(edit_field), 0);
    presses(B_UP, 23); press(B_ND); presses(B_UP, 59);
    chk("s1_2359_h", int'(disp_hour), 23);
    chk("s1_2359_m", int'(disp_min), 59);
    press(B_ND); presses(B_UP, 2);
    chk("hwrap_h", int'(disp_hour), 1);
    chk("hwrap_m", int'(disp_min), 59);
    press(B_ND); press(B_UP);
    chk("mwrap_h", int'(disp_hour), 1);
    chk("mwrap_m", int'(disp_min), 0);

    // Slots 1 and 3 at 06:00, armed.
    press(B_ND); presses(B_UP, 5);
    chk("s1_0600", int'(disp_hour), 6);
    sel = 3; reopen_edit(); presses(B_UP, 6);
    press(B_ARM); sel = 1; tick(); press(B_ARM);
    chk("armed_13", int'(armed), 4'b1010);
    setValue = 0; cur_hour = 6; cur_min = 0; tick();

    // Timeout after exactly BEEP sec_ticks.
    mtick();
    chk("ring_beep", int'(alarmBeep), 1);
    chk("ring_idx", int'(ring_idx), 1);
    repeat (BEEP - 1) stick();
    chk("beep_29", int'(alarmBeep), 1);
    stick();
    chk("beep_30", int'(alarmBeep), 0);
    chk("idx_idle", int'(ring_idx), 0);

    // Snooze cycles; matches during snooze are ignored.
    mtick();
    for (int k = 0; k < MAXS; k++) begin
      press(B_SNZ);
      chk("snz_quiet", int'(alarmBeep), 0);
      chk("snz_idx", int'(ring_idx), 1);
      repeat (SNZ - 1) mtick();
      chk("snz_4min", int'(alarmBeep), 0);
      mtick();
      chk("snz_rering", int'(alarmBeep), 1);
    end
    press(B_SNZ);
    chk("snz4_beep", int'(alarmBeep), 0);
    chk("snz4_idle", int'(ring_idx), 0);
    cur_min = 1; repeat (SNZ) mtick();
    chk("snz4_stays", int'(alarmBeep), 0);
    cur_min = 0;

    // Stop and snooze edge together.
    mtick();
    chk("ring2", int'(alarmBeep), 1);
    stop = 1; snooze = 1; tick(); stop = 0; snooze = 0; tick();
    chk("stop_snz_beep", int'(alarmBeep), 0);
    chk("stop_snz_idx", int'(ring_idx), 0);

    // Disarm ends ring; next match picks slot 3; editing it keeps ring.
    mtick(); sel = 1; tick(); press(B_ARM);
    chk("disarm_beep", int'(alarmBeep), 0);
    chk("disarm_arm", int'(armed), 4'b1000);
    mtick();
    chk("ring3_idx", int'(ring_idx), 3);
    sel = 3; reopen_edit(); press(B_UP); setValue = 0;
    chk("edit_ring", int'(alarmBeep), 1);
    chk("edit_hour", int'(disp_hour), 7);
    press(B_SNZ);
    chk("snz3_idx", int'(ring_idx), 3);

    // Reset while snoozed.
    resetTime = 1; tick(); resetTime = 0;
    chk("rst2_beep", int'(alarmBeep), 0);
    chk("rst2_armed", int'(armed), 0);
    chk("rst2_idx", int'(ring_idx), 0);
    chk("rst2_hour", int'(disp_hour), 0);
    chk("rst2_min", int'(disp_min), 0);
    repeat (SNZ) mtick();
    chk("rst2_quiet", int'(alarmBeep), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
